// File: rtl/mips_cpu_wb_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU (A) and load/mult-div (B)
// writeback, with a registered write stage and a busy scoreboard for decode stalls.
module mips_cpu_wb_arbiter #(
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 0,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [4:0]        a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [4:0]        b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              rsv_valid,
    input  logic [4:0]        rsv_reg,
    input  logic [4:0]        query_reg_1,
    input  logic [4:0]        query_reg_2,
    output logic              busy_1,
    output logic              busy_2,
    output logic              busy_any,
    output logic [4:0]        write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en
);

    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e              last_grant_q, last_grant_d;
    logic [NREGS-1:0]    busy_q, busy_d;
    logic [4:0]          write_reg_q, write_reg_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                write_en_q, write_en_d;

    logic                a_xfer, b_xfer, xfer;
    logic [4:0]          xfer_reg;
    logic [DATA_W-1:0]   xfer_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_B;
            busy_q       <= '0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            write_en_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            write_en_q   <= write_en_d;
        end
    end

    always_comb begin
        // Readies never look at the port's own valid, so both can be high but
        // at most one transfer happens: with both valid they are mutually exclusive.
        a_ready      = !b_valid || (last_grant_q == GRANT_B);
        b_ready      = !a_valid || (last_grant_q == GRANT_A);
        a_xfer       = a_valid && a_ready;
        b_xfer       = b_valid && b_ready;
        xfer         = a_xfer || b_xfer;
        xfer_reg     = a_xfer ? a_reg  : b_reg;
        xfer_data    = a_xfer ? a_data : b_data;

        last_grant_d = last_grant_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        write_en_d   = 1'b0;
        busy_d       = busy_q;

        if (a_xfer) begin
            last_grant_d = GRANT_A;
        end else if (b_xfer) begin
            last_grant_d = GRANT_B;
        end

        if (xfer) begin
            write_reg_d      = xfer_reg;
            write_data_d     = xfer_data;
            write_en_d       = (xfer_reg != ZERO_IDX);
            busy_d[xfer_reg] = 1'b0;
        end

        // Applied after the clear so a fresh reservation supersedes a completing write.
        if (rsv_valid && (rsv_reg != ZERO_IDX)) begin
            busy_d[rsv_reg] = 1'b1;
        end
        busy_d[ZERO_IDX] = 1'b0;
    end

    assign busy_1     = busy_q[query_reg_1];
    assign busy_2     = busy_q[query_reg_2];
    assign busy_any   = |busy_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign write_en   = write_en_q;

endmodule
